// File: rtl/lcd_pkg.sv
// ============================================================================
// Package : lcd_pkg
// Brief   : Shared types and constants for the LCD frame fetcher.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int unsigned c_H_RES_DEFAULT = 320;
    localparam int unsigned c_V_RES_DEFAULT = 240;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    // Counter width for values 0..n-1; a 1-value range still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_frame_fetch_if.sv
// ============================================================================
// Interface: lcd_frame_fetch_if
// Brief    : ROM read port plus outgoing pixel stream of the frame fetcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_frame_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic                  pix_eol;

    modport master (
        output rom_addr,
        input  rom_data,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output pix_sof,
        output pix_eol
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  pix_sof,
        input  pix_eol
    );
endinterface

`default_nettype wire

// File: rtl/lcd_skid_fifo.sv
// ============================================================================
// Module  : lcd_skid_fifo
// Brief   : 2-entry skid FIFO; a push is accepted when full if a pop happens.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_skid_fifo #(
    parameter int unsigned WIDTH = 18
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic      [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/lcd_frame_fetch.sv
// ============================================================================
// Module  : lcd_frame_fetch
// Brief   : Streams an image from a 1-cycle-latency block ROM as tagged pixels.
//           Define LCD_FETCH_LOOP_EN for continuous, start-free frame looping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_frame_fetch
    import lcd_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 17,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           H_RES      = c_H_RES_DEFAULT,
    parameter int unsigned           V_RES      = c_V_RES_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    output logic              busy,
    output logic              done,
    lcd_frame_fetch_if.master bus
);

    localparam int unsigned c_X_W  = cnt_width(H_RES);
    localparam int unsigned c_Y_W  = cnt_width(V_RES);
    localparam int unsigned c_FW   = DATA_WIDTH + 2;
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(H_RES - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(V_RES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_X_W-1:0]      r_x;
    logic [c_Y_W-1:0]      r_y;
    logic                  r_inflight;
    pix_tag_t              r_inflight_tag;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_drain_done;
    logic                  w_done_nxt;
    logic                  w_issue;
    logic                  w_last_rd;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic [1:0]            w_fifo_count;
    logic [c_FW-1:0]       w_head;
    pix_tag_t              w_rd_tag;
    pix_tag_t              w_head_tag;

    // Occupancy counts data already queued plus the word still in the ROM.
    assign w_pop     = bus.pix_valid & bus.pix_ready;
    assign w_occ     = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == FETCH) && (w_occ < 3'd2);
    assign w_last_rd = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    assign w_rd_tag.sof = (r_x == '0) && (r_y == '0);
    assign w_rd_tag.eol = (r_x == c_X_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_ok   = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            IDLE: begin
                // The done cycle is already IDLE, but a request there is dropped.
                if (start && !r_done) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
`ifdef LCD_FETCH_LOOP_EN
                w_state_nxt = FETCH;
`else
                if (w_issue && w_last_rd) begin
                    w_state_nxt = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (!r_inflight &&
                    ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop))) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef LCD_FETCH_LOOP_EN
    localparam int unsigned c_P_W = cnt_width(H_RES * V_RES);
    localparam logic [c_P_W-1:0] c_P_LAST = c_P_W'(H_RES * V_RES - 1);

    logic [c_P_W-1:0] r_pix_cnt;

    // Frames never drain, so the frame boundary is found by counting handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
        end else if (w_start_ok) begin
            r_pix_cnt <= '0;
        end else if (w_pop) begin
            r_pix_cnt <= (r_pix_cnt == c_P_LAST) ? '0 : r_pix_cnt + c_P_W'(1);
        end
    end

    assign w_done_nxt = w_pop && (r_pix_cnt == c_P_LAST);
`else
    assign w_done_nxt = w_drain_done;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= BASE_ADDR;
            r_x            <= '0;
            r_y            <= '0;
            r_inflight     <= 1'b0;
            r_inflight_tag <= '0;
            r_done         <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_done_nxt;
            if (w_issue) begin
                r_inflight_tag <= w_rd_tag;
            end
            if (w_start_ok) begin
                r_addr <= BASE_ADDR;
                r_x    <= '0;
                r_y    <= '0;
            end else if (w_issue) begin
`ifdef LCD_FETCH_LOOP_EN
                r_addr <= w_last_rd ? BASE_ADDR : r_addr + ADDR_WIDTH'(1);
`else
                r_addr <= r_addr + ADDR_WIDTH'(1);
`endif
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_LAST) ? '0 : r_y + c_Y_W'(1);
                end else begin
                    r_x <= r_x + c_X_W'(1);
                end
            end
        end
    end

    lcd_skid_fifo #(
        .WIDTH (c_FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data ({r_inflight_tag, bus.rom_data}),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign w_head_tag    = pix_tag_t'(w_head[c_FW-1:DATA_WIDTH]);
    assign bus.rom_addr  = r_addr;
    assign bus.pix_valid = (w_fifo_count != 2'd0);
    assign bus.pix_data  = w_head[DATA_WIDTH-1:0];
    assign bus.pix_sof   = bus.pix_valid & w_head_tag.sof;
    assign bus.pix_eol   = bus.pix_valid & w_head_tag.eol;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

endmodule

`default_nettype wire

// File: doc/lcd_frame_fetch.md
# lcd_frame_fetch

Frame fetcher that reads an image out of a synchronous, 1-cycle-latency block ROM and streams it as a pixel stream toward the LCD output path. It drives the ROM address port and captures the ROM data port. It absorbs the fixed read latency with a 2-entry skid buffer, so downstream backpressure never drops or duplicates a pixel. It sits between the image ROM and the LCD timing/serialiser logic, and is triggered once per frame.

## Interface
- ADDR_WIDTH, 17: ROM address width.
- DATA_WIDTH, 16: ROM word and pixel width (RGB565).
- H_RES, 320: pixels per line.
- V_RES, 240: lines per frame.
- BASE_ADDR, 0: ROM word address of pixel (0,0).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request pulse; sampled only in IDLE.
- busy  out  1  high from the first FETCH cycle until `done`.
- done  out  1  one-cycle pulse after the last pixel handshake.
- rom_addr  out  ADDR_WIDTH  ROM read address; the ROM registers it every edge.
- rom_data  in  DATA_WIDTH  ROM output, valid one edge after `rom_addr`.
- pix_data  out  DATA_WIDTH  pixel word.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts; handshake = `pix_valid & pix_ready`.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_eol  out  1  qualifies the last pixel of each line (x = H_RES-1).

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - FETCH: issues reads.
  - DRAIN: all H_RES*V_RES reads issued; waits for FIFO empty and no read in flight.
  - IDLE again: `done` pulses on the transition into IDLE.
- Reads and the read pipeline:
  - A read issues when `(fifo_count + inflight - pop) < 2`, where `pop` is the handshake this cycle.
  - `inflight` is a 1-bit valid pipeline matching the ROM latency.
  - When `inflight` is set, the returning `rom_data` is pushed into the FIFO together with its sof/eol tags.
- Address and position:
  - `rom_addr` = BASE_ADDR + issued-read count; it advances by 1 per issued read and holds otherwise.
  - Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
  - Separate x/y counters (clog2 widths) produce the tags. x wraps at H_RES-1 and increments y.
- Start handling:
  - `start` is ignored while busy.
  - `start` in the same cycle as `done` is ignored; the request must come in IDLE.
- Stream rules:
  - `pix_data`, `pix_sof` and `pix_eol` are held stable while `pix_valid & !pix_ready`.
  - `pix_valid` never drops without a handshake.
- Reset values: `busy`, `done`, `pix_valid`, `pix_sof` and `pix_eol` are 0; `pix_data` is 0; `rom_addr` is BASE_ADDR; FIFO is empty; `inflight` is 0; state is IDLE.
- Reset mid-frame: everything returns immediately to the reset values and the in-flight read is discarded. The next `start` begins again at pixel (0,0).

## Timing
- Start latency: if `start` is sampled at edge n, then
  - `busy` is high and `rom_addr` = BASE_ADDR after edge n;
  - the first `pix_valid` goes high after edge n+2.
- Throughput: 1 pixel/cycle when `pix_ready` is held high, with no bubbles across line boundaries.
- Backpressure: the FIFO never overflows. Maximum occupancy is 2; the issue rule guarantees this.
- Completion: `done` is high for exactly the one cycle after the edge that completes the final handshake; `busy` falls in that same cycle.
- Frame size: H_RES*V_RES must be ≤ 2^ADDR_WIDTH. Values of 1 for H_RES or V_RES are legal; with H_RES = 1, sof and eol coincide.

## Configuration
- `LCD_FETCH_LOOP_EN` defined:
  - After the last read issues, the block restarts at BASE_ADDR, pixel (0,0), without waiting for `start`.
  - DRAIN is skipped and `busy` stays high.
  - `done` still pulses once per frame, in the cycle after the last handshake.
  - No bubble appears between frames when `pix_ready` = 1.
- Undefined: single-shot behaviour as described above.

## Structure
- Package `lcd_pkg`:
  - default H_RES/V_RES constants;
  - FSM state enum (IDLE, FETCH, DRAIN);
  - pixel-tag struct {sof, eol}.
- Sub-module `lcd_skid_fifo`:
  - 2-entry, width DATA_WIDTH+2;
  - push/pop/count interface;
  - pop and push may occur in the same cycle when full.

## Test plan
- Reset: assert `rst_n` = 0 mid-simulation → all outputs at their reset values, `rom_addr` = BASE_ADDR, no `pix_valid`.
- Basic frame: H_RES=4, V_RES=2, ROM word = address, `pix_ready` = 1, `start` at edge n → `pix_valid` after n+2; pixels 0..7 on consecutive cycles; sof on 0; eol on 3 and 7; single `done`; `busy` low afterwards.
- Backpressure: same frame with `pix_ready` randomised at 50% → exact sequence 0..7, data stable while stalled, FIFO occupancy ≤ 2.
- Spurious start: `start` pulsed at pixel 2, and again in the `done` cycle → neither starts a new frame; only one `done`.
- Reset mid-frame: `rst_n` low after pixel 3 handshakes, then `start` → stream restarts at pixel 0 with sof.
- `LCD_FETCH_LOOP_EN`: H_RES=4, V_RES=2, one `start` → 16 gapless pixels 0..7,0..7; sof on the 1st and 9th; `done` pulses twice; `busy` stays high.
